div_16x8_seq: RTL

Iterative restoring divider, the inverse of the 8x8 approximate multipliers. It takes a 16-bit product-domain value and an 8-bit operand and recovers the other 8-bit operand, so multiplier outputs can be checked in closed loop and reused in divide paths. It computes one quotient bit per cycle. An optional approximate mode skips low quotient bits to cut latency, in the same accuracy/latency trade-off style as the library's multipliers. Valid/ready handshakes on input and output.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 23 ++
 rtl/div_16x8_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared widths, FSM state type and divide-by-zero constant for the 16x8 divider.
package div_pkg;

   localparam int unsigned DVD_W = 16;
   localparam int unsigned DVS_W = 8;

   localparam logic [DVD_W-1:0] DIV0_QUOT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module div_step
   import div_pkg::*;
(
   input  logic [DVS_W-1:0] pr,
   input  logic             dvd_bit,
   input  logic [DVS_W-1:0] divisor,
   output logic [DVS_W-1:0] pr_next,
   output logic             q_bit
);

   logic [DVS_W:0] trial;
   logic [DVS_W:0] diff;

   // The partial remainder stays below the divisor, so 9 bits cover the trial value.
   always_comb begin
      trial   = {pr, dvd_bit};
      diff    = trial - {1'b0, divisor};
      q_bit   = (trial >= {1'b0, divisor});
      pr_next = q_bit ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
   end

endmodule

// File: rtl/div_16x8_seq.sv
// Iterative restoring divider, 16-bit dividend by 8-bit divisor, one quotient bit
// per cycle, with optional skipping of the APPROX_LSB lowest quotient bits.
module div_16x8_seq
   import div_pkg::*;
#(
   parameter int unsigned APPROX_LSB = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DVD_W-1:0]  dividend,
   input  logic [DVS_W-1:0]  divisor,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DVD_W-1:0]  quotient,
   output logic [DVD_W-1:0]  remainder,
   output logic              div_zero,
   output logic              q_ovf
);

   localparam int unsigned N_ITER = DVD_W - APPROX_LSB;
   localparam logic [3:0] LAST_IDX = 4'(APPROX_LSB);
   localparam logic [DVD_W-1:0] LOW_MASK = DVD_W'((32'd1 << APPROX_LSB) - 32'd1);

   div_state_t       state;
   logic [DVD_W-1:0] dvd;
   logic [DVS_W-1:0] dvs;
   logic [DVS_W-1:0] pr;
   logic [DVD_W-1:0] q;
   logic [3:0]       idx;

   logic [DVS_W-1:0] pr_nxt;
   logic             q_bit;
   logic [DVD_W-1:0] q_nxt;
   logic [DVD_W-1:0] rem_fin;

   div_step u_step (
      .pr      (pr),
      .dvd_bit (dvd[idx]),
      .divisor (dvs),
      .pr_next (pr_nxt),
      .q_bit   (q_bit)
   );

   // Merge the new quotient bit and form the final remainder, re-attaching the
   // dividend bits that were never shifted through the step.
   always_comb begin
      q_nxt   = q | (DVD_W'(q_bit) << idx);
      rem_fin = (DVD_W'(pr_nxt) << APPROX_LSB) | (dvd & LOW_MASK);
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         q_ovf     <= 1'b0;
         dvd       <= '0;
         dvs       <= '0;
         pr        <= '0;
         q         <= '0;
         idx       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (divisor == '0) begin
                     quotient  <= DIV0_QUOT;
                     remainder <= dividend;
                     div_zero  <= 1'b1;
                     q_ovf     <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     dvd   <= dividend;
                     dvs   <= divisor;
                     pr    <= '0;
                     q     <= '0;
                     idx   <= 4'(DVD_W - 1);
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               pr  <= pr_nxt;
               q   <= q_nxt;
               idx <= idx - 4'd1;
               if (idx == LAST_IDX) begin
                  quotient  <= q_nxt & ~LOW_MASK;
                  remainder <= rem_fin;
                  q_ovf     <= |q_nxt[DVD_W-1:DVS_W];
                  div_zero  <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // N_ITER is the per-divide iteration count; kept for readability of latency math.
   logic unused_ok;
   always_comb unused_ok = (N_ITER != 0);

endmodule
